// File: rtl/zigbee_fm_discriminator.sv
// -----------------------------------------------------------------------------
// zigbee_fm_discriminator
//
// Frequency discriminator for O-QPSK/MSK chip recovery. It takes the phase
// differences between consecutive valid CORDIC phase samples, sums OSR of
// them per chip, and decides the chip value from the sign of that sum.
// Because the phase wraps modulo 2^W_SIZE, the natural two's-complement
// difference is already the shortest signed rotation.
//
// Parameters
//   W_SIZE  phase width (signed, 64 steps per turn at the default of 6)
//   OSR     phase samples per chip (2..16)
//
// Ports
//   clk        in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   wout       in   signed phase sample
//   oValid     in   phase sample strobe
//   clear      in   synchronous chip-boundary resync (zeroes counter/sum)
//   chip       out  chip decision, 1 = positive frequency
//   chipValid  out  one-cycle strobe qualifying chip/chipSum
//   chipSum    out  signed per-chip accumulated phase difference
//
// Optional build macro ZIGBEE_DISC_FREQ_OUT_EN adds:
//   freq       out  registered per-sample phase difference
//   freqValid  out  one-cycle strobe after each computed difference
// -----------------------------------------------------------------------------
module zigbee_fm_discriminator #(
  parameter  int W_SIZE = 6,
  parameter  int OSR    = 4,
  localparam int CNT_W  = $clog2(OSR),
  localparam int SUM_W  = W_SIZE + CNT_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [W_SIZE-1:0] wout,
  input  logic                     oValid,
  input  logic                     clear,
  output logic                     chip,
  output logic                     chipValid,
  output logic signed [SUM_W-1:0]  chipSum
`ifdef ZIGBEE_DISC_FREQ_OUT_EN
  ,
  output logic signed [W_SIZE-1:0] freq,
  output logic                     freqValid
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,  // no previous phase held yet
    RUN   = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic signed [W_SIZE-1:0]  phase_prev_q, phase_prev_d;
  logic signed [SUM_W-1:0]   acc_q, acc_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic                      chip_q, chip_d;
  logic signed [SUM_W-1:0]   chip_sum_q, chip_sum_d;
  logic                      chip_valid_q, chip_valid_d;

  logic signed [W_SIZE-1:0]  diff;
  logic signed [SUM_W-1:0]   sum_full;
  logic                      diff_take;

  // W_SIZE-bit subtraction wraps modulo 2^W_SIZE, giving the shortest rotation.
  assign diff     = wout - phase_prev_q;
  assign sum_full = acc_q + {{CNT_W{diff[W_SIZE-1]}}, diff};

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    phase_prev_d = phase_prev_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    chip_d       = chip_q;
    chip_sum_d   = chip_sum_q;
    chip_valid_d = 1'b0;
    diff_take    = 1'b0;

    if (oValid) begin
      phase_prev_d = wout;
      if (state_q == EMPTY) state_d = RUN;
      else                  diff_take = 1'b1;
    end

    // clear wins over a same-cycle diff: that diff is dropped.
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (diff_take) begin
      if (cnt_q == CNT_W'(OSR - 1)) begin
        chip_sum_d   = sum_full;
        chip_d       = !sum_full[SUM_W-1] && (sum_full != '0);
        chip_valid_d = 1'b1;
        acc_d        = '0;
        cnt_d        = '0;
      end else begin
        acc_d = sum_full;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_prev_q <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      chip_q       <= 1'b0;
      chip_sum_q   <= '0;
      chip_valid_q <= 1'b0;
    end else begin
      phase_prev_q <= phase_prev_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      chip_q       <= chip_d;
      chip_sum_q   <= chip_sum_d;
      chip_valid_q <= chip_valid_d;
    end
  end

  assign chip      = chip_q;
  assign chipValid = chip_valid_q;
  assign chipSum   = chip_sum_q;

`ifdef ZIGBEE_DISC_FREQ_OUT_EN
  // Raw per-sample frequency tap; deliberately independent of clear.
  logic signed [W_SIZE-1:0] freq_q;
  logic                     freq_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freq_q       <= '0;
      freq_valid_q <= 1'b0;
    end else begin
      freq_valid_q <= diff_take;
      if (diff_take) freq_q <= diff;
    end
  end

  assign freq      = freq_q;
  assign freqValid = freq_valid_q;
`endif

endmodule
